// File: rtl/channel_readout_scheduler_if.sv
// Bus bundle for channel_readout_scheduler: trigger FIFO, channel FIFOs and
// the single-channel framer. "master" is the scheduler's view, "slave" is
// the view of whatever surrounds it.
interface channel_readout_scheduler_if #(
    parameter int NUM_CHAN = 5
);
    // Trigger / fill-number FIFO (first-word-fall-through)
    logic [23:0]            tm_data;
    logic                   tm_valid;
    logic                   tm_ready;

    // Channel FIFOs, channel i at [32i+31:32i]
    logic [NUM_CHAN*32-1:0] chan_data;
    logic [NUM_CHAN-1:0]    chan_last;
    logic [NUM_CHAN-1:0]    chan_valid;
    logic [NUM_CHAN-1:0]    chan_ready;

    // Framer side
    logic [23:0]            xfer_tm_data;
    logic                   xfer_tm_valid;
    logic                   xfer_tm_ready;
    logic [31:0]            xfer_chan_data;
    logic                   xfer_chan_last;
    logic                   xfer_chan_valid;
    logic                   xfer_chan_ready;

    modport master (
        input  tm_data, tm_valid,
        output tm_ready,
        input  chan_data, chan_last, chan_valid,
        output chan_ready,
        output xfer_tm_data, xfer_tm_valid,
        input  xfer_tm_ready,
        output xfer_chan_data, xfer_chan_last, xfer_chan_valid,
        input  xfer_chan_ready
    );

    modport slave (
        output tm_data, tm_valid,
        input  tm_ready,
        output chan_data, chan_last, chan_valid,
        input  chan_ready,
        input  xfer_tm_data, xfer_tm_valid,
        output xfer_tm_ready,
        input  xfer_chan_data, xfer_chan_last, xfer_chan_valid,
        output xfer_chan_ready
    );
endinterface

// File: rtl/channel_readout_scheduler.sv
// channel_readout_scheduler: per trigger, walks the enabled channels in
// ascending order, hands the fill number to the framer once per channel and
// then passes that channel's FIFO stream straight through until its last word.
// Optional macro CHAN_TIMEOUT_EN: per-channel stall timeout that closes a
// stuck channel with a synthetic 0xDEAD<chan> last beat and sets timeout_err.
module channel_readout_scheduler #(
    parameter int NUM_CHAN       = 5,
    parameter int CHAN_W         = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CHAN-1:0]     enable_mask,
    channel_readout_scheduler_if.master bus,
    output logic                    busy,
    output logic [CHAN_W-1:0]       cur_chan,
    output logic [15:0]             event_count,
    output logic                    timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_STREAM,
        S_NEXT,
        S_POP
    } state_t;

    state_t              state, state_d;
    logic [23:0]         fill;
    logic [NUM_CHAN-1:0] mask_q;

    logic                load_found;
    logic [CHAN_W-1:0]   load_idx;
    logic                next_found;
    logic [CHAN_W-1:0]   next_idx;

    logic [31:0]         sel_data;
    logic                sel_last;
    logic                sel_valid;

    logic                in_stream;
    logic                synth;
    logic                beat;

    assign in_stream = (state == S_STREAM);

    // Priority pick: lowest enabled channel at LOAD, next enabled one above cur_chan at NEXT
    always_comb begin
        load_found = 1'b0;
        load_idx   = '0;
        next_found = 1'b0;
        next_idx   = '0;
        for (int unsigned i = 0; i < NUM_CHAN; i++) begin
            if (enable_mask[i] && !load_found) begin
                load_found = 1'b1;
                load_idx   = CHAN_W'(i);
            end
            if (mask_q[i] && (i > 32'(cur_chan)) && !next_found) begin
                next_found = 1'b1;
                next_idx   = CHAN_W'(i);
            end
        end
    end

    // Select the current channel's FIFO head
    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_CHAN; i++) begin
            if (cur_chan == CHAN_W'(i)) begin
                sel_data  = bus.chan_data[i*32 +: 32];
                sel_last  = bus.chan_last[i];
                sel_valid = bus.chan_valid[i];
            end
        end
    end

`ifdef CHAN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt;
    logic             synth_hold;

    // Once the synthetic beat starts it is held until the framer takes it,
    // even if the real channel becomes valid in the meantime.
    assign synth = in_stream &&
                   (synth_hold || ((to_cnt == CNT_W'(TIMEOUT_CYCLES)) && !sel_valid));

    // Stall counter and synthetic-beat hold, cleared outside STREAM and on every beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= '0;
            synth_hold  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (!in_stream) begin
                to_cnt     <= '0;
                synth_hold <= 1'b0;
            end else begin
                if (beat)
                    to_cnt <= '0;
                else if (to_cnt != CNT_W'(TIMEOUT_CYCLES))
                    to_cnt <= to_cnt + 1'b1;
                synth_hold <= synth && !bus.xfer_chan_ready;
            end
            if (synth)
                timeout_err <= 1'b1;
        end
    end
`else
    assign synth       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign bus.xfer_chan_valid = in_stream & (synth | sel_valid);
    assign bus.xfer_chan_last  = in_stream & (synth | sel_last);
    assign bus.xfer_chan_data  = !in_stream ? '0 :
                                 synth      ? {16'hDEAD, 16'(cur_chan)} : sel_data;
    assign beat                = bus.xfer_chan_valid & bus.xfer_chan_ready;

    assign bus.xfer_tm_valid   = (state == S_ISSUE);
    assign bus.xfer_tm_data    = fill;
    assign bus.tm_ready        = (state == S_POP);
    assign busy                = (state != S_IDLE);

    // Pop only the selected channel, and never while a synthetic beat is shown
    always_comb begin
        bus.chan_ready = '0;
        for (int unsigned i = 0; i < NUM_CHAN; i++) begin
            if (in_stream && !synth && (cur_chan == CHAN_W'(i)))
                bus.chan_ready[i] = bus.xfer_chan_ready;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:   if (bus.tm_valid) state_d = S_LOAD;
            S_LOAD:   state_d = load_found ? S_ISSUE : S_POP;
            S_ISSUE:  if (bus.xfer_tm_ready) state_d = S_STREAM;
            S_STREAM: if (beat && bus.xfer_chan_last) state_d = S_NEXT;
            S_NEXT:   state_d = next_found ? S_ISSUE : S_POP;
            S_POP:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Event datapath: fill/mask snapshot, channel pointer, completed-event counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill        <= '0;
            mask_q      <= '0;
            cur_chan    <= '0;
            event_count <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    fill   <= bus.tm_data;
                    mask_q <= enable_mask;
                    if (load_found)
                        cur_chan <= load_idx;
                end
                S_NEXT: begin
                    if (next_found)
                        cur_chan <= next_idx;
                end
                S_POP:   event_count <= event_count + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/channel_readout_scheduler.md
Name: channel_readout_scheduler

Overview:
- Sequences per-fill readout of NUM_CHAN channel FIFOs through the single-channel DAQ transfer block (header / data / trailer framer).
- For each trigger, hands one fill number to the framer per enabled channel, then routes that channel's 32-bit FIFO stream to the framer until its last word.
- Sits between the trigger/fill-number FIFO, the channel FIFOs and the framer.

Parameters:
- NUM_CHAN, 5, number of channel FIFOs (1..8).
- CHAN_W, 3, width of the channel index; must satisfy 2^CHAN_W >= NUM_CHAN.
- TIMEOUT_CYCLES, 4096, stall limit per channel; used only with CHAN_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable_mask  in  NUM_CHAN  channel enables; snapshotted at trigger accept.
- tm_data  in  24  fill number from the trigger FIFO (first-word-fall-through).
- tm_valid  in  1  trigger FIFO not empty.
- tm_ready  out  1  trigger FIFO pop, one-cycle pulse.
- chan_data  in  NUM_CHAN*32  channel FIFO words; channel i occupies [32i+31:32i].
- chan_last  in  NUM_CHAN  last word of the fill, per channel.
- chan_valid  in  NUM_CHAN  channel FIFO not empty.
- chan_ready  out  NUM_CHAN  channel FIFO pop.
- xfer_tm_data  out  24  fill number to the framer.
- xfer_tm_valid  out  1  fill number valid.
- xfer_tm_ready  in  1  framer idle and accepting.
- xfer_chan_data  out  32  muxed channel word.
- xfer_chan_last  out  1  muxed last flag.
- xfer_chan_valid  out  1  muxed valid.
- xfer_chan_ready  in  1  framer ready for a channel word.
- busy  out  1  high in any state other than IDLE.
- cur_chan  out  CHAN_W  channel currently selected.
- event_count  out  16  completed triggers; wraps at 16'hFFFF -> 0.
- timeout_err  out  1  sticky error flag; 0 when CHAN_TIMEOUT_EN is not defined.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; all outputs 0; fill, mask snapshot and counters cleared. Reset mid-event abandons the event with no pop of the trigger FIFO.
- States:
  - IDLE: on tm_valid -> LOAD.
  - LOAD: latch fill = tm_data and mask_q = enable_mask. If mask_q == 0 -> POP; otherwise cur_chan = lowest set bit -> ISSUE.
  - ISSUE: xfer_tm_valid = 1 and xfer_tm_data = fill, held until xfer_tm_ready; on handshake -> STREAM.
  - STREAM: combinational pass-through, zero latency.
    - xfer_chan_data/last/valid = chan_*[cur_chan], with valid gated by the STREAM state.
    - chan_ready[i] = STREAM & (i == cur_chan) & xfer_chan_ready; all other chan_ready bits are 0.
    - A beat transfers when xfer_chan_valid & xfer_chan_ready.
    - A transferred beat with last set -> NEXT.
  - NEXT: pick the lowest set mask_q bit above cur_chan; if one exists -> ISSUE with the new cur_chan, else -> POP.
  - POP: tm_ready = 1 for exactly one cycle; event_count increments -> IDLE.
- Timing: minimum 1 idle cycle between events (IDLE -> LOAD); back-to-back triggers are serviced without extra gaps.
- Channel ordering is strictly ascending index within an event and is not round-robin across events.
- Mask changes during an event have no effect until the next LOAD.
- Channels with a mask bit of 0 are never popped.
- Whether the framer is between channels is determined only by xfer_tm_ready; the scheduler never issues while the framer is busy.
- chan_valid on a non-selected channel is ignored.
- A last word on the first beat is legal (1-word fill).

Optional Feature:
- Macro: CHAN_TIMEOUT_EN.
- Defined:
  - A counter runs in STREAM and clears on every transferred beat.
  - When it reaches TIMEOUT_CYCLES with xfer_chan_valid low, the scheduler drives a synthetic beat: xfer_chan_data = {16'hDEAD, 13'h0, cur_chan}, xfer_chan_last = 1, xfer_chan_valid = 1, with chan_ready held 0.
  - The synthetic beat holds until xfer_chan_ready, then -> NEXT.
  - timeout_err sets and stays set until reset.
- Not defined: no counter; timeout_err tied to 0; STREAM waits indefinitely.

Test Plan:
- mask=5'b00101, tm_data=24'h000123, ch0 3 words (last on 3rd), ch2 1 word -> two ISSUE handshakes with xfer_tm_data=24'h000123; output order ch0 w0..w2 then ch2 w0; one tm_ready pulse; event_count=1.
- mask=0, tm_valid=1 -> no xfer_tm_valid; tm_ready pulse 2 cycles after tm_valid rises; event_count increments.
- xfer_chan_ready toggled 1/0 every cycle during a 4-word ch1 stream -> exactly 4 chan_ready[1] pops; no duplicated or dropped words.
- mask changed from 5'b00011 to 5'b10000 while streaming ch0 -> ch1 still read; ch4 untouched; chan_ready[4] never asserted.
- rst_n pulsed low in STREAM -> all outputs 0 immediately; tm_ready never pulses; the next trigger restarts from LOAD.
- CHAN_TIMEOUT_EN with TIMEOUT_CYCLES=16, ch3 never valid -> after 16 cycles xfer_chan_data=32'hDEAD0003, last=1; timeout_err=1; scheduler proceeds to next channel / POP.
